keypad_sync_debounce: RTL and testbench
=======================================

Name: keypad_sync_debounce

Overview:
- Parametrised multi-stage synchronizer with per-channel debounce and edge detection for asynchronous keypad and switch inputs.
- Sits between the keypad column pins and the keypad scan FSM.
- Delivers metastability-safe raw bits, debounced stable bits, and single-cycle rise/fall pulses, so the scanner needs no debounce logic of its own.

Parameters:
- WIDTH, 4: number of independent input channels.
- STAGES, 2: synchronizer flop depth; legal range >= 2.
- DEBOUNCE_CYCLES, 4: consecutive qualifying samples required to accept a new level; legal range >= 1.
- RESET_VAL, {WIDTH{1'b1}}: reset level of the synchronizer chain and of stable. Default is all ones because columns are pulled up (idle high).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- sample_en  input  1  debounce sample strobe; tie high to sample every clk.
- col_async  input  WIDTH  raw asynchronous inputs.
- col_sync  output  WIDTH  output of the last synchronizer stage.
- col_stable  output  WIDTH  debounced level.
- col_rise  output  WIDTH  one-cycle pulse when col_stable goes 0->1.
- col_fall  output  WIDTH  one-cycle pulse when col_stable goes 1->0.
- any_change  output  1  one-cycle pulse; the OR of all col_rise and col_fall bits.

Behaviour:
Reset:
- reset low asynchronously forces every synchronizer stage and col_stable to RESET_VAL.
- It also clears all debounce counters, col_rise, col_fall and any_change to 0.
- Reset asserted mid-debounce discards any in-progress count; no pulse is produced.
- Outputs are valid from the first clk edge after reset deasserts.

Synchronizer:
- STAGES-deep flop chain per bit, no logic between stages.
- col_sync reflects col_async after exactly STAGES clk edges.
- col_sync is independent of sample_en.

Debounce, per channel i, with counter width clog2(DEBOUNCE_CYCLES+1):
- col_sync[i] == col_stable[i]: counter clears to 0 on the next edge, regardless of sample_en.
- Mismatch with sample_en=0: counter holds.
- Mismatch with sample_en=1 and counter < DEBOUNCE_CYCLES-1: counter increments.
- Mismatch with sample_en=1 and counter == DEBOUNCE_CYCLES-1:
  - col_stable[i] <= col_sync[i];
  - counter <= 0;
  - the matching edge pulse is registered in the same edge.
- A mismatch that disappears before acceptance (a glitch) leaves col_stable unchanged and resets the counter.
- DEBOUNCE_CYCLES=1: col_stable takes col_sync on the first sample_en edge of a mismatch.
- Channels are fully independent. Simultaneous acceptances on several channels each produce their own pulse; any_change asserts once for that cycle.

Edges:
- col_rise[i] and col_fall[i] are registered.
- They are high for exactly one clk, in the same cycle col_stable[i] first shows the new value.
- They are never both high on one channel.

Latency:
- With sample_en held high and an input step held constant, col_stable and the pulse appear STAGES+DEBOUNCE_CYCLES clk edges after the first edge that samples the new level.

Counters:
- Counters never exceed DEBOUNCE_CYCLES-1.
- There is no wrap-around; a saturated mismatch always resolves to acceptance.

Test Plan:
1. Reset behaviour: reset low with col_async=4'h0 -> col_sync=col_stable=4'hF, all pulses 0. Release reset -> col_sync becomes 4'h0 after 2 edges, col_stable=4'h0 after 6 edges, col_fall=4'hF and any_change=1 for exactly 1 cycle.
2. Glitch rejection: col_async[2] low for 3 clk, then high (defaults, sample_en=1) -> col_stable stays 4'hF and no pulses. Hold low for 4+ clk -> col_stable=4'hB and col_fall=4'b0100 for one cycle.
3. Strobed sampling: sample_en high 1 cycle in 8, with col_async[0] falling and holding -> col_stable[0] falls on the 4th sample_en edge after col_sync[0] changes. The counter holds between strobes.
4. Multi-channel event: same cycle, col[1] falls and col[3] rises from 4'b0111 (stable) -> col_fall=4'b0010 and col_rise=4'b1000 in the same cycle; any_change pulses once.
5. Mid-count reset: counter at 2 on channel 0, then reset pulsed low for 1 cycle -> col_stable=RESET_VAL, no pulse. Debounce restarts and needs the full 4 samples afterwards.
6. Parameter sweep: WIDTH=1, STAGES=3, DEBOUNCE_CYCLES=1, RESET_VAL=0 -> input rise gives col_stable=1 after 4 edges with a single col_rise pulse.

Source files
------------

// File: rtl/keypad_sync_debounce.sv
// Multi-stage synchronizer, per-channel debounce and registered rise/fall pulses for keypad columns.
// Step latency STAGES+DEBOUNCE_CYCLES edges with sample_en high; no backpressure, results arrive every clk.
module keypad_sync_debounce #(
   parameter int                WIDTH           = 4,
   parameter int                STAGES          = 2,
   parameter int                DEBOUNCE_CYCLES = 4,
   parameter logic [WIDTH-1:0]  RESET_VAL       = {WIDTH{1'b1}}
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             sample_en,
   input  logic [WIDTH-1:0] col_async,
   output logic [WIDTH-1:0] col_sync,
   output logic [WIDTH-1:0] col_stable,
   output logic [WIDTH-1:0] col_rise,
   output logic [WIDTH-1:0] col_fall,
   output logic             any_change
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [WIDTH-1:0] sync_q [STAGES];
   logic [CW-1:0]    cnt    [WIDTH];
   logic [WIDTH-1:0] accept;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int s = 0; s < STAGES; s++) sync_q[s] <= RESET_VAL;
      end else begin
         sync_q[0] <= col_async;
         for (int s = 1; s < STAGES; s++) sync_q[s] <= sync_q[s-1];
      end
   end

   assign col_sync = sync_q[STAGES-1];

   // A channel accepts its new level on the qualifying sample that would push the count past LAST.
   always_comb begin
      accept = '0;
      for (int i = 0; i < WIDTH; i++)
         accept[i] = (col_sync[i] != col_stable[i]) && sample_en && (cnt[i] == LAST);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
         col_stable <= RESET_VAL;
         col_rise   <= '0;
         col_fall   <= '0;
         any_change <= 1'b0;
      end else begin
         for (int i = 0; i < WIDTH; i++) begin
            if (col_sync[i] == col_stable[i])
               cnt[i] <= '0;
            else if (sample_en)
               cnt[i] <= accept[i] ? '0 : cnt[i] + CW'(1);
         end
         col_stable <= (col_stable & ~accept) | (col_sync & accept);
         col_rise   <= accept & col_sync;
         col_fall   <= accept & ~col_sync;
         any_change <= |accept;
      end
   end

endmodule

// File: tb/tb_keypad_sync_debounce.sv
// Scoreboarded bench: a run-length reference model predicts every cycle's outputs for two DUT configurations.
module tb_keypad_sync_debounce;

   typedef struct packed {
      logic [3:0] sync;
      logic [3:0] stable;
      logic [3:0] rise;
      logic [3:0] fall;
      logic       any;
   } exp_t;

   logic       clk;
   logic       reset;
   logic       sample_en;
   logic [3:0] col_async;
   logic [3:0] col_sync, col_stable, col_rise, col_fall;
   logic       any_change;
   logic       p_async;
   logic       p_sync, p_stable, p_rise, p_fall, p_any;

   keypad_sync_debounce u_dut (
      .clk(clk), .reset(reset), .sample_en(sample_en), .col_async(col_async),
      .col_sync(col_sync), .col_stable(col_stable), .col_rise(col_rise),
      .col_fall(col_fall), .any_change(any_change)
   );

   keypad_sync_debounce #(.WIDTH(1), .STAGES(3), .DEBOUNCE_CYCLES(1), .RESET_VAL(1'b0)) u_p (
      .clk(clk), .reset(reset), .sample_en(sample_en), .col_async(p_async),
      .col_sync(p_sync), .col_stable(p_stable), .col_rise(p_rise),
      .col_fall(p_fall), .any_change(p_any)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int   checks = 0;
   int   failures = 0;
   exp_t q0[$];
   exp_t q1[$];

   // Reference state: input history per stage, accepted level, qualifying samples in the current mismatch run.
   logic [3:0] m_pipe   [2][3];
   logic [3:0] m_stable [2];
   int         m_run    [2][4];

   task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   task automatic model_step(input int k, input int w, input int s, input int d,
                             input logic [3:0] rv, input logic rst_n, input logic en,
                             input logic [3:0] a, output exp_t e);
      logic [3:0] seen;
      logic [3:0] mask;
      mask = (w == 4) ? 4'hF : 4'h1;
      e = '0;
      if (!rst_n) begin
         for (int j = 0; j < 3; j++) m_pipe[k][j] = rv;
         m_stable[k] = rv;
         for (int i = 0; i < 4; i++) m_run[k][i] = 0;
      end else begin
         seen = m_pipe[k][s-1];
         for (int j = 2; j > 0; j--) m_pipe[k][j] = m_pipe[k][j-1];
         m_pipe[k][0] = a;
         for (int i = 0; i < w; i++) begin
            if (seen[i] == m_stable[k][i]) begin
               m_run[k][i] = 0;
            end else if (en) begin
               m_run[k][i] = m_run[k][i] + 1;
               if (m_run[k][i] == d) begin
                  m_stable[k][i] = seen[i];
                  m_run[k][i] = 0;
                  if (seen[i]) e.rise[i] = 1'b1;
                  else         e.fall[i] = 1'b1;
               end
            end
         end
      end
      e.sync   = m_pipe[k][s-1] & mask;
      e.stable = m_stable[k] & mask;
      e.rise   = e.rise & mask;
      e.fall   = e.fall & mask;
      e.any    = |(e.rise | e.fall);
   endtask

   task automatic step(input logic rst_n, input logic en, input logic [3:0] a, input logic pa);
      exp_t e;
      @(negedge clk);
      reset = rst_n;
      sample_en = en;
      col_async = a;
      p_async = pa;
      model_step(0, 4, 2, 4, 4'hF, rst_n, en, a, e);
      q0.push_back(e);
      model_step(1, 1, 3, 1, 4'h0, rst_n, en, {3'b0, pa}, e);
      q1.push_back(e);
   endtask

   // Monitor: every clk the DUTs present a full set of outputs, checked against the oldest prediction.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q0.size() > 0) begin
            e = q0.pop_front();
            check("sync", col_sync, e.sync);
            check("stable", col_stable, e.stable);
            check("rise", col_rise, e.rise);
            check("fall", col_fall, e.fall);
            check("any", {3'b0, any_change}, {3'b0, e.any});
         end
         if (q1.size() > 0) begin
            e = q1.pop_front();
            check("p_sync", {3'b0, p_sync}, e.sync);
            check("p_stable", {3'b0, p_stable}, e.stable);
            check("p_rise", {3'b0, p_rise}, e.rise);
            check("p_fall", {3'b0, p_fall}, e.fall);
            check("p_any", {3'b0, p_any}, {3'b0, e.any});
         end
      end
   end

   initial begin
      logic [3:0] a;
      logic       pa;
      reset = 1'b0;
      sample_en = 1'b1;
      col_async = 4'h0;
      p_async = 1'b0;

      // Reset with inputs low, then release: falls on all channels after 6 edges.
      for (int c = 0; c < 3; c++) step(1'b0, 1'b1, 4'h0, 1'b0);
      for (int c = 0; c < 10; c++) step(1'b1, 1'b1, 4'h0, 1'b1);

      // Back to idle high, then a 3-cycle glitch on col 2, then a held low.
      for (int c = 0; c < 10; c++) step(1'b1, 1'b1, 4'hF, 1'b0);
      for (int c = 0; c < 3; c++) step(1'b1, 1'b1, 4'hB, 1'b0);
      for (int c = 0; c < 10; c++) step(1'b1, 1'b1, 4'hF, 1'b0);
      for (int c = 0; c < 10; c++) step(1'b1, 1'b1, 4'hB, 1'b1);
      for (int c = 0; c < 10; c++) step(1'b1, 1'b1, 4'hF, 1'b1);

      // Strobed sampling, one strobe in eight, col 0 falling and held.
      for (int c = 0; c < 48; c++) step(1'b1, (c % 8) == 7, 4'hE, 1'b0);

      // Simultaneous fall on col 1 and rise on col 3 from 4'b0111.
      for (int c = 0; c < 10; c++) step(1'b1, 1'b1, 4'h7, 1'b0);
      for (int c = 0; c < 10; c++) step(1'b1, 1'b1, 4'hD, 1'b1);

      // Mid-count reset on col 0, then a full debounce afterwards.
      for (int c = 0; c < 10; c++) step(1'b1, 1'b1, 4'hF, 1'b0);
      for (int c = 0; c < 4; c++) step(1'b1, 1'b1, 4'hE, 1'b0);
      step(1'b0, 1'b1, 4'hE, 1'b0);
      for (int c = 0; c < 10; c++) step(1'b1, 1'b1, 4'hE, 1'b0);

      // Random: sparse toggles so both glitches and acceptances occur, random strobes, rare resets.
      a = 4'hF;
      pa = 1'b0;
      for (int c = 0; c < 2000; c++) begin
         for (int i = 0; i < 4; i++)
            if ($urandom_range(0, 5) == 0) a[i] = ~a[i];
         if ($urandom_range(0, 3) == 0) pa = ~pa;
         step(($urandom_range(0, 299) != 0), ($urandom_range(0, 3) != 0), a, pa);
      end

      @(negedge clk);
      @(negedge clk);
      check("queue_drain", 4'(q0.size() + q1.size()), 4'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
